// File: rtl/memory_port_arbiter_if.sv
// Bundle of IF-stage, MEM-stage and memory-side signals around the memory port arbiter.
// The arbiter uses the slave modport; the pipeline/memory side uses master.
interface memory_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     if_request;
  logic [ADDRESS_WIDTH-1:0] if_address;
  logic                     if_ready;
  logic [DATA_WIDTH-1:0]    if_readData;

  logic                     mem_request;
  logic                     mem_shouldWrite;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_writeData;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_readData;

  logic                     memory_request;
  logic                     memory_shouldWrite;
  logic [ADDRESS_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0]    memory_writeData;
  logic                     memory_acknowledge;
  logic [DATA_WIDTH-1:0]    memory_readData;

  logic                     shouldStall;
  logic                     timeout;

  modport slave (
    input  if_request, if_address,
    input  mem_request, mem_shouldWrite, mem_address, mem_writeData,
    input  memory_acknowledge, memory_readData,
    output if_ready, if_readData, mem_ready, mem_readData,
    output memory_request, memory_shouldWrite, memory_address, memory_writeData,
    output shouldStall, timeout
  );

  modport master (
    output if_request, if_address,
    output mem_request, mem_shouldWrite, mem_address, mem_writeData,
    output memory_acknowledge, memory_readData,
    input  if_ready, if_readData, mem_ready, mem_readData,
    input  memory_request, memory_shouldWrite, memory_address, memory_writeData,
    input  shouldStall, timeout
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one access at a time.
// Ready pulses one cycle after acknowledge; unacknowledged accesses are abandoned after TIMEOUT_CYCLES.
module memory_port_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     last_mem_q, last_mem_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     if_ready_q, if_ready_d;
  logic                     mem_ready_q, mem_ready_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]    mem_rdata_q, mem_rdata_d;
  logic                     timeout_q, timeout_d;

  logic                     if_elig, mem_elig;
  logic                     done;
  logic [DATA_WIDTH-1:0]    done_data;

  // A port whose ready is pulsing still has its request up this cycle; keep it out of arbitration.
  assign if_elig  = bus.if_request  & ~if_ready_q;
  assign mem_elig = bus.mem_request & ~mem_ready_q;

  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    timeout_d   = timeout_q;
    done        = 1'b0;
    done_data   = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_elig && (!if_elig || !last_mem_q)) begin
          state_d    = SERVE_MEM;
          last_mem_d = 1'b1;
          we_d       = bus.mem_shouldWrite;
          addr_d     = bus.mem_address;
          wdata_d    = bus.mem_writeData;
        end else if (if_elig) begin
          state_d    = SERVE_IF;
          last_mem_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = bus.if_address;
          wdata_d    = '0;
        end
      end
      SERVE_IF, SERVE_MEM: begin
        if (bus.memory_acknowledge) begin
          state_d   = IDLE;
          done      = 1'b1;
          done_data = bus.memory_readData;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // Abandoned access completes with zero data so the pipeline never deadlocks.
          state_d   = IDLE;
          done      = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (state_q == SERVE_IF) begin
        if_ready_d = 1'b1;
        if_rdata_d = done_data;
      end else begin
        mem_ready_d = 1'b1;
        if (!we_q) mem_rdata_d = done_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.memory_request     = (state_q != IDLE);
  assign bus.memory_shouldWrite = we_q;
  assign bus.memory_address     = addr_q;
  assign bus.memory_writeData   = wdata_q;
  assign bus.if_ready           = if_ready_q;
  assign bus.if_readData        = if_rdata_q;
  assign bus.mem_ready          = mem_ready_q;
  assign bus.mem_readData       = mem_rdata_q;
  assign bus.timeout            = timeout_q;
  assign bus.shouldStall        = (bus.if_request & ~if_ready_q) | (bus.mem_request & ~mem_ready_q);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized scoreboard bench: requesters push expected responses, a monitor pops them on ready pulses.
module tb_memory_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_port_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          is_store;
    bit          dead;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  wr_t  wr_q[$];

  int tests = 0;
  int fails = 0;

  logic [31:0] if_hold, mem_hold;
  bit          exp_to;
  int          mem_while_if, if_while_mem;

  // Memory model state
  bit          active;
  int          cyc, lat;
  logic [31:0] c_addr, c_wd;
  logic        c_we;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Readable memory contents: a fixed function of the address. Addresses with bit 31 set never acknowledge.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] make_addr(input bit dead);
    logic [31:0] r;
    r = $urandom();
    return {dead, r[30:2], 2'b00};
  endfunction

  task automatic clear_model();
    if_q.delete();
    mem_q.delete();
    wr_q.delete();
    if_hold      = '0;
    mem_hold     = '0;
    exp_to       = 1'b0;
    mem_while_if = 0;
    if_while_mem = 0;
  endtask

  // Monitor: compares every ready pulse and the held/combinational outputs each cycle
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.if_ready) begin
        if (if_q.size() == 0) fail_now("if_ready_unexpected");
        else begin
          exp_t e;
          e = if_q.pop_front();
          if (e.dead) exp_to = 1'b1;
          if_hold = e.dead ? 32'h0 : e.data;
          check("if_fairness_ok", 64'(mem_while_if <= 1), 64'd1);
          mem_while_if = 0;
        end
      end
      if (bus.mem_ready) begin
        if (mem_q.size() == 0) fail_now("mem_ready_unexpected");
        else begin
          exp_t e;
          e = mem_q.pop_front();
          if (e.dead) exp_to = 1'b1;
          if (!e.is_store) mem_hold = e.dead ? 32'h0 : e.data;
          check("mem_fairness_ok", 64'(if_while_mem <= 1), 64'd1);
          if_while_mem = 0;
        end
      end
      if (bus.mem_ready && bus.if_request && !bus.if_ready) mem_while_if++;
      if (bus.if_ready && bus.mem_request && !bus.mem_ready) if_while_mem++;
      check("if_readData", bus.if_readData, if_hold);
      check("mem_readData", bus.mem_readData, mem_hold);
      check("timeout", bus.timeout, exp_to);
      check("shouldStall", bus.shouldStall,
            (bus.if_request & ~bus.if_ready) | (bus.mem_request & ~bus.mem_ready));
    end
  end

  // Memory responder with random latency 0..3 extra cycles
  always @(negedge clock) begin
    if (reset) begin
      active = 1'b0;
      bus.memory_acknowledge = 1'b0;
    end else if (bus.memory_request) begin
      if (!active) begin
        active = 1'b1;
        cyc    = 0;
        lat    = $urandom_range(0, 3);
        c_addr = bus.memory_address;
        c_we   = bus.memory_shouldWrite;
        c_wd   = bus.memory_writeData;
      end else begin
        check("addr_stable", bus.memory_address, c_addr);
        check("we_stable", bus.memory_shouldWrite, c_we);
        check("wdata_stable", bus.memory_writeData, c_wd);
      end
      cyc++;
      if (!c_addr[31] && cyc == lat + 1) begin
        bus.memory_acknowledge = 1'b1;
        bus.memory_readData    = c_we ? $urandom() : rom(c_addr);
        if (c_we) begin
          if (wr_q.size() == 0) fail_now("write_unexpected");
          else begin
            wr_t w;
            w = wr_q.pop_front();
            check("write_addr", c_addr, w.addr);
            check("write_data", c_wd, w.data);
          end
        end
        active = 1'b0;
      end else begin
        bus.memory_acknowledge = 1'b0;
        bus.memory_readData    = $urandom();
      end
    end else begin
      if (active) begin
        check("timeout_request_cycles", 64'(cyc), 64'(TO));
        active = 1'b0;
      end
      bus.memory_acknowledge = 1'b0;
    end
  end

  task automatic run_if(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      exp_t        e;
      bit          got;
      a = make_addr((i % 7) == 3);
      bus.if_address = a;
      bus.if_request = 1'b1;
      e.is_store = 1'b0;
      e.dead     = a[31];
      e.data     = rom(a);
      if_q.push_back(e);
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clock);
        if (bus.if_ready) begin
          got = 1'b1;
          break;
        end
      end
      check("if_ready_seen", 64'(got), 64'd1);
      @(posedge clock); #1;
      bus.if_request = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic run_mem(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, wd;
      exp_t        e;
      wr_t         w;
      bit          st, got;
      a  = make_addr((i % 9) == 5);
      wd = $urandom();
      st = ($urandom_range(0, 2) == 0);
      bus.mem_address     = a;
      bus.mem_writeData   = wd;
      bus.mem_shouldWrite = st;
      bus.mem_request     = 1'b1;
      e.is_store = st;
      e.dead     = a[31];
      e.data     = rom(a);
      mem_q.push_back(e);
      if (st && !a[31]) begin
        w.addr = a;
        w.data = wd;
        wr_q.push_back(w);
      end
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clock);
        if (bus.mem_ready) begin
          got = 1'b1;
          break;
        end
      end
      check("mem_ready_seen", 64'(got), 64'd1);
      @(posedge clock); #1;
      bus.mem_request = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    int km, ki;
    bit dm, di;
    bus.if_request         = 1'b0;
    bus.if_address         = '0;
    bus.mem_request        = 1'b0;
    bus.mem_shouldWrite    = 1'b0;
    bus.mem_address        = '0;
    bus.mem_writeData      = '0;
    bus.memory_acknowledge = 1'b0;
    bus.memory_readData    = '0;
    clear_model();
    reset = 1'b1;
    #1;
    check("rst_memory_request", bus.memory_request, 0);
    check("rst_memory_shouldWrite", bus.memory_shouldWrite, 0);
    check("rst_memory_address", bus.memory_address, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_mem_ready", bus.mem_ready, 0);
    check("rst_if_readData", bus.if_readData, 0);
    check("rst_mem_readData", bus.mem_readData, 0);
    check("rst_timeout", bus.timeout, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    fork
      run_if(40);
      run_mem(40);
    join
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("if_q_drained", 64'(if_q.size()), 0);
    check("mem_q_drained", 64'(mem_q.size()), 0);
    check("wr_q_drained", 64'(wr_q.size()), 0);

    // Reset during the second cycle of a never-acknowledged load
    bus.mem_address     = 32'h8000_0200;
    bus.mem_shouldWrite = 1'b0;
    bus.mem_request     = 1'b1;
    @(posedge clock); #1;
    check("abort_request_up", bus.memory_request, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    clear_model();
    #1;
    check("abort_request_dropped", bus.memory_request, 0);
    check("abort_timeout", bus.timeout, 0);
    check("abort_mem_ready", bus.mem_ready, 0);
    bus.mem_request = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("post_reset_no_mem_ready", bus.mem_ready, 0);
    end

    // After reset the MEM port wins a simultaneous request
    @(posedge clock); #1;
    begin
      exp_t e;
      bus.if_address      = 32'h40;
      bus.if_request      = 1'b1;
      bus.mem_address     = 32'h80;
      bus.mem_shouldWrite = 1'b0;
      bus.mem_request     = 1'b1;
      e.is_store = 1'b0;
      e.dead     = 1'b0;
      e.data     = rom(32'h80);
      mem_q.push_back(e);
      e.data = rom(32'h40);
      if_q.push_back(e);
    end
    @(posedge clock); #1;
    check("first_grant_mem_addr", bus.memory_address, 32'h80);
    dm = 1'b0; di = 1'b0; km = -1; ki = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.mem_ready) begin dm = 1'b1; km = k; end
      if (bus.if_ready) begin di = 1'b1; ki = k; end
      @(posedge clock); #1;
      if (dm) bus.mem_request = 1'b0;
      if (di) bus.if_request = 1'b0;
      if (dm && di) break;
    end
    check("both_served", 64'({dm, di}), 64'b11);
    check("mem_before_if", 64'(km < ki), 64'd1);
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
